// File: rtl/fcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcp_pkg
// Description : FCP update field layout shared by the sink queue and its users.
// Revision    : 1.0
// ============================================================================
package fcp_pkg;

  localparam int FCP_DEF_STAT_WIDTH = 32;
  localparam int FCP_DEF_VC_WIDTH   = 15;

  typedef enum logic [1:0] {
    FLD_FCCL = 2'd0,
    FLD_QLEN = 2'd1,
    FLD_FCCR = 2'd2,
    FLD_VC   = 2'd3
  } fcp_field_e;

  // Fields sit back to back from bit 0, each statistic STAT_WIDTH wide, VC last.
  function automatic int fcp_offset(input fcp_field_e fld, input int stat_width);
    return int'(fld) * stat_width;
  endfunction

  function automatic int fcp_used_width(input int stat_width, input int vc_width);
    return 3 * stat_width + vc_width;
  endfunction

  // Default-width view of an update; member order matches the bit layout.
  typedef struct packed {
    logic [FCP_DEF_VC_WIDTH-1:0]   vc;
    logic [FCP_DEF_STAT_WIDTH-1:0] fccr;
    logic [FCP_DEF_STAT_WIDTH-1:0] qlen;
    logic [FCP_DEF_STAT_WIDTH-1:0] fccl;
  } fcp_update_t;

endpackage
`default_nettype wire

// File: rtl/fcp_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fcp_sink_fifo
// Description : Synchronous FIFO, power-of-two depth, count-based full/empty.
// Revision    : 1.0
// ============================================================================
module fcp_sink_fifo #(
  parameter int WIDTH = 111,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Both flags derive from the registered count only, so a read never frees space combinationally.
  assign o_wr_ready = !rst && (r_count < c_depth);
  assign o_rd_valid = !rst && (r_count != '0);
  assign w_push     = i_wr_en && o_wr_ready;
  assign w_pop      = i_rd_en && o_rd_valid;
  assign o_rd_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/fcp_sink_queue.sv
`default_nettype none
// ============================================================================
// Module      : fcp_sink_queue
// Description : Decodes AXI-Stream FCP updates, drops illegal VCs, buffers the
//               rest for a valid/ready consumer. FCP_SINK_STATS_EN adds counters.
// Revision    : 1.0
// ============================================================================
module fcp_sink_queue
  import fcp_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 15,
  parameter int STAT_WIDTH        = 32,
  parameter int AXIS_WIDTH        = 128,
  parameter int NUM_VC            = 32768,
  parameter int DEPTH             = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_WIDTH-1:0]        s_axis_fcp_tdata,
  input  logic                         s_axis_fcp_tvalid,
  output logic                         s_axis_fcp_tready,
  output logic                         fcp_valid,
  input  logic                         fcp_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  output logic [STAT_WIDTH-1:0]        fcp_fccl,
  output logic [STAT_WIDTH-1:0]        fcp_qlen,
  output logic [STAT_WIDTH-1:0]        fcp_fccr
`ifdef FCP_SINK_STATS_EN
  ,
  output logic [31:0]                  stat_accepted,
  output logic [31:0]                  stat_dropped
`endif
);

  localparam int c_used      = fcp_used_width(STAT_WIDTH, QUEUE_INDEX_WIDTH);
  localparam int c_off_fccl  = fcp_offset(FLD_FCCL, STAT_WIDTH);
  localparam int c_off_qlen  = fcp_offset(FLD_QLEN, STAT_WIDTH);
  localparam int c_off_fccr  = fcp_offset(FLD_FCCR, STAT_WIDTH);
  localparam int c_off_vc    = fcp_offset(FLD_VC, STAT_WIDTH);
  localparam logic [QUEUE_INDEX_WIDTH:0] c_num_vc = (QUEUE_INDEX_WIDTH + 1)'(NUM_VC);

  if (AXIS_WIDTH < c_used) begin : g_err_axis_width
    $error("fcp_sink_queue: AXIS_WIDTH too small for the FCP fields");
  end
  if (64'(NUM_VC) > (64'd1 << QUEUE_INDEX_WIDTH)) begin : g_err_num_vc
    $error("fcp_sink_queue: NUM_VC exceeds the VC index range");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
    $error("fcp_sink_queue: DEPTH must be a power of two, at least 2");
  end
  if (AXIS_WIDTH > c_used) begin : g_unused_tdata
    logic w_unused_tdata;
    assign w_unused_tdata = ^s_axis_fcp_tdata[AXIS_WIDTH-1:c_used];
  end

  logic [QUEUE_INDEX_WIDTH-1:0] w_vc;
  logic                         w_accept;
  logic                         w_vc_ok;
  logic                         w_wr;
  logic                         w_drop;
  logic [c_used-1:0]            w_rd_data;

  assign w_vc     = s_axis_fcp_tdata[c_off_vc +: QUEUE_INDEX_WIDTH];
  assign w_accept = s_axis_fcp_tvalid && s_axis_fcp_tready;
  assign w_vc_ok  = ({1'b0, w_vc} < c_num_vc);
  assign w_wr     = w_accept && w_vc_ok;
  assign w_drop   = w_accept && !w_vc_ok;

  // The stored word keeps the input layout, so the same offsets decode it on the way out.
  fcp_sink_fifo #(
    .WIDTH (c_used),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr),
    .i_wr_data  (s_axis_fcp_tdata[c_used-1:0]),
    .o_wr_ready (s_axis_fcp_tready),
    .i_rd_en    (fcp_ready),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (fcp_valid)
  );

  assign fcp_fccl = w_rd_data[c_off_fccl +: STAT_WIDTH];
  assign fcp_qlen = w_rd_data[c_off_qlen +: STAT_WIDTH];
  assign fcp_fccr = w_rd_data[c_off_fccr +: STAT_WIDTH];
  assign fcp_vc   = w_rd_data[c_off_vc +: QUEUE_INDEX_WIDTH];

`ifdef FCP_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (w_wr && (stat_accepted != '1))  stat_accepted <= stat_accepted + 1'b1;
      if (w_drop && (stat_dropped != '1)) stat_dropped  <= stat_dropped + 1'b1;
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = w_wr ^ w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fcp_sink_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcp_sink_queue
// Description : Self-checking bench for fcp_sink_queue (NUM_VC=16, DEPTH=8);
//               stat checks are compiled in with FCP_SINK_STATS_EN.
// Revision    : 1.0
// ============================================================================
module tb_fcp_sink_queue;
  import fcp_pkg::*;

  localparam int QIW = 15;
  localparam int SW  = 32;
  localparam int AW  = 128;
  localparam int NVC = 16;
  localparam int DP  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          fvalid;
  logic          fready;
  logic [QIW-1:0] fvc;
  logic [SW-1:0] fccl;
  logic [SW-1:0] qlen;
  logic [SW-1:0] fccr;
`ifdef FCP_SINK_STATS_EN
  logic [31:0]   sacc;
  logic [31:0]   sdrop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcp_sink_queue #(
    .QUEUE_INDEX_WIDTH (QIW),
    .STAT_WIDTH        (SW),
    .AXIS_WIDTH        (AW),
    .NUM_VC            (NVC),
    .DEPTH             (DP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_fcp_tdata  (tdata),
    .s_axis_fcp_tvalid (tvalid),
    .s_axis_fcp_tready (tready),
    .fcp_valid         (fvalid),
    .fcp_ready         (fready),
    .fcp_vc            (fvc),
    .fcp_fccl          (fccl),
    .fcp_qlen          (qlen),
    .fcp_fccr          (fccr)
`ifdef FCP_SINK_STATS_EN
    ,
    .stat_accepted     (sacc),
    .stat_dropped      (sdrop)
`endif
  );

  typedef struct {
    logic [QIW-1:0] vc;
    logic [SW-1:0]  fccl;
    logic [SW-1:0]  qlen;
    logic [SW-1:0]  fccr;
    bit             exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic fcp_update_t mku(input int vc, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] c);
    fcp_update_t u;
    u.vc   = QIW'(vc);
    u.fccl = a;
    u.qlen = b;
    u.fccr = c;
    return u;
  endfunction

  // Bits above the packed update are filled with noise; the DUT must ignore them.
  function automatic logic [AW-1:0] mk(input fcp_update_t u);
    logic [AW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[$bits(fcp_update_t)-1:0] = u;
    return d;
  endfunction

  function automatic fcp_update_t rnd_upd(input int max_vc);
    return mku($urandom_range(0, max_vc), $urandom, $urandom, $urandom);
  endfunction

  task automatic chk_out(input string name, input fcp_update_t e);
    chk({name, "_vc"},   64'(fvc),  64'(e.vc));
    chk({name, "_fccl"}, 64'(fccl), 64'(e.fccl));
    chk({name, "_qlen"}, 64'(qlen), 64'(e.qlen));
    chk({name, "_fccr"}, 64'(fccr), 64'(e.fccr));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; tvalid = 1'b0; fready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  vec_t        tbl[6];
  fcp_update_t exp_q[$];
  fcp_update_t got_q[$];
  fcp_update_t u;
  int          m_acc;
  int          m_drop;
  int          n_acc;

  initial begin
    rst = 1'b1; tvalid = 1'b0; fready = 1'b0; tdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_valid",  64'(fvalid), 64'd0);
`ifdef FCP_SINK_STATS_EN
    chk("rst_sacc",  64'(sacc),  64'd0);
    chk("rst_sdrop", 64'(sdrop), 64'd0);
`endif
    rst = 1'b0;
    tick;
    chk("post_rst_tready", 64'(tready), 64'd1);
    chk("post_rst_valid",  64'(fvalid), 64'd0);

    // Single-beat vectors with the consumer always ready.
    tbl[0] = '{5,  32'h100,      32'h20,       32'hF0,       1'b1};
    tbl[1] = '{15, 32'hDEADBEEF, 32'h1,        32'h2,        1'b1};
    tbl[2] = '{16, 32'h11,       32'h22,       32'h33,       1'b0};
    tbl[3] = '{0,  32'h0,        32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[4] = '{20, 32'h44,       32'h55,       32'h66,       1'b0};
    tbl[5] = '{7,  32'hFFFFFFFF, 32'h0,        32'hA5A5A5A5, 1'b1};
    for (int i = 0; i < 6; i++) begin
      u = mku(int'(tbl[i].vc), tbl[i].fccl, tbl[i].qlen, tbl[i].fccr);
      tdata = mk(u); tvalid = 1'b1; fready = 1'b1;
      tick;
      tvalid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(fvalid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk_out($sformatf("vec%0d", i), u);
      tick;
      chk($sformatf("vec%0d_valid_gone", i), 64'(fvalid), 64'd0);
    end

    // Fill with consumer stalled: 8 of 10 back-to-back beats are taken.
    do_reset;
    exp_q.delete();
    n_acc = 0;
    fready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      u = rnd_upd(NVC - 1);
      tdata = mk(u); tvalid = 1'b1;
      #1;
      if (i == 8) chk("fill_tready_beat9", 64'(tready), 64'd0);
      if (tready) begin
        n_acc++;
        exp_q.push_back(u);
      end
      tick;
    end
    tvalid = 1'b0;
    chk("fill_accepted", 64'(n_acc), 64'd8);
    chk("fill_tready_full", 64'(tready), 64'd0);
    fready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), 64'(fvalid), 64'd1);
      chk_out($sformatf("drain%0d", i), exp_q.pop_front());
      tick;
      if (i == 0) chk("drain_tready_after_first", 64'(tready), 64'd1);
    end
    chk("drain_empty", 64'(fvalid), 64'd0);

    // VC filter: 3, 20, 7 in -> 3, 7 out.
    do_reset;
    got_q.delete();
    fready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tvalid = (i < 3);
      tdata = mk(mku((i == 0) ? 3 : (i == 1) ? 20 : 7, i, i, i));
      #1;
      if (fvalid) got_q.push_back(mku(int'(fvc), fccl, qlen, fccr));
      tick;
    end
    tvalid = 1'b0;
    chk("filter_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("filter_vc0", 64'(got_q[0].vc), 64'd3);
      chk("filter_vc1", 64'(got_q[1].vc), 64'd7);
    end
`ifdef FCP_SINK_STATS_EN
    chk("filter_sacc",  64'(sacc),  64'd2);
    chk("filter_sdrop", 64'(sdrop), 64'd1);
`endif

    // Streaming: one output per cycle over 100 beats.
    exp_q.delete();
    fready = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin
        chk($sformatf("stream%0d_valid", k - 1), 64'(fvalid), 64'd1);
        chk_out($sformatf("stream%0d", k - 1), exp_q.pop_front());
      end
      if (k < 100) begin
        u = rnd_upd(NVC - 1);
        exp_q.push_back(u);
        tdata = mk(u); tvalid = 1'b1;
        #1;
        chk($sformatf("stream%0d_tready", k), 64'(tready), 64'd1);
      end else begin
        tvalid = 1'b0;
      end
      tick;
    end
    chk("stream_empty", 64'(fvalid), 64'd0);

    // Reset with 5 entries buffered.
    fready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tdata = mk(rnd_upd(NVC - 1)); tvalid = 1'b1;
      tick;
    end
    tvalid = 1'b0;
    chk("pre_rst_valid", 64'(fvalid), 64'd1);
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", 64'(fvalid), 64'd0);
`ifdef FCP_SINK_STATS_EN
    chk("mid_rst_sacc", 64'(sacc), 64'd0);
`endif
    rst = 1'b0;
    u = mku(9, 32'h1234, 32'h5678, 32'h9ABC);
    tdata = mk(u); tvalid = 1'b1; fready = 1'b1;
    #1;
    chk("after_rst_tready", 64'(tready), 64'd1);
    tick;
    tvalid = 1'b0;
    chk("after_rst_valid", 64'(fvalid), 64'd1);
    chk_out("after_rst", u);
    tick;
    chk("after_rst_drained", 64'(fvalid), 64'd0);

    // Random traffic against a queue model.
    do_reset;
    exp_q.delete();
    m_acc = 0; m_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      rst    = (c < 2990) && ($urandom_range(0, 199) == 0);
      tvalid = ($urandom_range(0, 3) != 0);
      fready = ($urandom_range(0, 2) != 0);
      u      = rnd_upd(23);
      tdata  = mk(u);
      #1;
      chk("rnd_tready", 64'(tready), 64'(!rst && (exp_q.size() < DP)));
      chk("rnd_valid",  64'(fvalid), 64'(!rst && (exp_q.size() > 0)));
      if (!rst && exp_q.size() > 0) chk_out("rnd", exp_q[0]);
`ifdef FCP_SINK_STATS_EN
      chk("rnd_sacc",  64'(sacc),  64'(m_acc));
      chk("rnd_sdrop", 64'(sdrop), 64'(m_drop));
`endif
      if (rst) begin
        exp_q.delete();
        m_acc = 0; m_drop = 0;
      end else begin
        bit can_wr;
        can_wr = tvalid && (exp_q.size() < DP);
        if (fready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (can_wr) begin
          if (int'(u.vc) < NVC) begin
            exp_q.push_back(u);
            m_acc++;
          end else begin
            m_drop++;
          end
        end
      end
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
